// File: rtl/midi_cmd_parser_pkg.sv
// midi_cmd_parser_pkg: MIDI status nibbles, controller numbers, command words and parser states
package midi_cmd_parser_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SKIP} state_t;

    localparam logic [3:0]  ST_NOTE_OFF      = 4'h8;
    localparam logic [3:0]  ST_NOTE_ON       = 4'h9;
    localparam logic [3:0]  ST_CC            = 4'hB;
    localparam logic [3:0]  ST_PROG          = 4'hC;

    localparam logic [6:0]  CC_ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0]  CC_ALL_NOTES_OFF = 7'd123;

    localparam logic [15:0] CMD_STOP_ALL     = 16'h7F00;
    localparam logic [15:0] CMD_WAVE_SWITCH  = 16'h8000;

endpackage

// File: rtl/midi_cmd_parser_fifo.sv
// cmd_fifo: show-ahead command FIFO; a push into a full FIFO is dropped unless a pop frees a slot
module cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic             w_push, w_pop, w_full;

    assign w_full  = r_count == (AW+1)'(DEPTH);
    assign o_valid = r_count != '0;
    assign w_pop   = i_pop && o_valid;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;
    assign o_data  = o_valid ? r_mem[r_rd] : '0;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/midi_cmd_parser.sv
// midi_cmd_parser: turns a MIDI byte stream into synthesizer command words queued in a FIFO
module midi_cmd_parser
    import midi_cmd_parser_pkg::*;
#(
    parameter int CHANNEL    = 0,
    parameter int OMNI       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [15:0] o_cmd,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic        o_overflow
);
    state_t      r_state, w_state_nxt;
    logic [3:0]  r_status, w_status_nxt;
    logic [6:0]  r_d1, w_d1_nxt;
    logic [15:0] r_word, w_word;
    logic        r_push, r_overflow, w_emit, w_drop;
    logic [3:0]  w_hi;
    logic        w_accept, w_note_ok, w_stop;

    assign w_hi      = i_byte[7:4];
    assign w_accept  = (OMNI != 0 || i_byte[3:0] == 4'(CHANNEL)) &&
                       (w_hi == ST_NOTE_OFF || w_hi == ST_NOTE_ON || w_hi == ST_CC || w_hi == ST_PROG);
    // note numbers 0 and 127 would alias the reserved control words
    assign w_note_ok = (r_status == ST_NOTE_OFF || r_status == ST_NOTE_ON) && r_d1 != 7'd0 && r_d1 != 7'h7F;
    assign w_stop    = r_status == ST_CC && (r_d1 == CC_ALL_SOUND_OFF || r_d1 == CC_ALL_NOTES_OFF);

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_d1_nxt     = r_d1;
        w_emit       = 1'b0;
        w_word       = 16'h0000;
        if (i_byte_valid && i_byte[7:3] != 5'b11111) begin
            if (i_byte[7]) begin
                w_state_nxt  = w_accept ? WAIT_D1 : SKIP;
                w_status_nxt = w_accept ? w_hi : 4'h0;
            end else if (r_state == WAIT_D1) begin
                w_d1_nxt    = i_byte[6:0];
                w_state_nxt = (r_status == ST_PROG) ? WAIT_D1 : WAIT_D2;
                w_emit      = r_status == ST_PROG;
                w_word      = CMD_WAVE_SWITCH;
            end else if (r_state == WAIT_D2) begin
                w_state_nxt = WAIT_D1;
                w_emit      = w_note_ok || w_stop;
                w_word      = w_stop ? CMD_STOP_ALL
                                     : {r_status == ST_NOTE_ON && i_byte[6:0] != 7'd0, r_d1, i_byte};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_status   <= 4'h0;
            r_d1       <= 7'd0;
            r_push     <= 1'b0;
            r_word     <= 16'h0000;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_status   <= w_status_nxt;
            r_d1       <= w_d1_nxt;
            r_push     <= w_emit;
            r_word     <= w_word;
            r_overflow <= r_overflow | w_drop;
        end
    end

    cmd_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push),
        .i_data  (r_word),
        .i_pop   (i_cmd_ready),
        .o_data  (o_cmd),
        .o_valid (o_cmd_valid),
        .o_drop  (w_drop)
    );

    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_midi_cmd_parser.sv
// tb_midi_cmd_parser: directed and randomized checks of midi_cmd_parser against a queue-level model
module tb_midi_cmd_parser;
    localparam int DEPTH = 4;
    localparam int CH    = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_valid = 1'b0;
    logic        i_cmd_ready = 1'b0;
    logic [15:0] o_cmd;
    logic        o_cmd_valid;
    logic        o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] got[$];
    logic [15:0] mq[$];
    logic        m_ovf = 1'b0;
    logic        pend_v = 1'b0;
    logic [15:0] pend_w = 16'h0000;
    int          m_rs = -1;
    int          m_data[$];

    always #5 clk = ~clk;

    midi_cmd_parser #(.CHANNEL(CH), .OMNI(0), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_cmd        (o_cmd),
        .o_cmd_valid  (o_cmd_valid),
        .i_cmd_ready  (i_cmd_ready),
        .o_overflow   (o_overflow)
    );

    task automatic emit(input int w);
        pend_v = 1'b1;
        pend_w = 16'(w);
    endtask

    // Message-level model: running status byte plus collected data bytes.
    task automatic model_byte(input int b);
        int typ, n, v;
        if (b >= 'hF8) return;
        if (b >= 'h80) begin
            m_data.delete();
            typ  = b >> 4;
            m_rs = ((typ == 8 || typ == 9 || typ == 11 || typ == 12) && (b & 15) == CH) ? b : -1;
            return;
        end
        if (m_rs < 0) return;
        m_data.push_back(b);
        typ = m_rs >> 4;
        if (typ == 12) begin
            emit('h8000);
            m_data.delete();
        end else if (m_data.size() == 2) begin
            n = m_data[0];
            v = m_data[1];
            m_data.delete();
            if (typ == 11) begin
                if (n == 120 || n == 123) emit('h7F00);
            end else if (n != 0 && n != 127) begin
                if (typ == 9 && v > 0) emit('h8000 + n * 256 + v);
                else if (typ == 9)     emit(n * 256);
                else                   emit(n * 256 + v);
            end
        end
    endtask

    // Cycle model: command appears in the queue one edge after its completing byte.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_data.delete();
            m_ovf  = 1'b0;
            pend_v = 1'b0;
            m_rs   = -1;
        end else begin
            if (mq.size() > 0 && i_cmd_ready) void'(mq.pop_front());
            if (pend_v) begin
                if (mq.size() < DEPTH) mq.push_back(pend_w);
                else m_ovf = 1'b1;
            end
            pend_v = 1'b0;
            if (i_byte_valid) model_byte(int'(i_byte));
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && o_cmd_valid && i_cmd_ready) got.push_back(o_cmd);
    end

    task automatic send(input logic [7:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(posedge clk); #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (o_cmd_valid !== 1'b0 || o_cmd !== 16'h0000 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset valid=%b cmd=%h ovf=%b expected 0/0000/0", o_cmd_valid, o_cmd, o_overflow);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_note_on();
        i_cmd_ready = 1'b1;
        got.delete();
        send(8'h90); send(8'h45); send(8'h64);
        @(negedge clk);
        n_checks++;
        if (o_cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL note_on_latency_early valid=%b expected 0", o_cmd_valid);
        end
        @(negedge clk);
        n_checks++;
        if (o_cmd_valid !== 1'b1 || o_cmd !== 16'hC564) begin
            n_fail++; $display("FAIL note_on_word valid=%b cmd=%h expected 1/c564", o_cmd_valid, o_cmd);
        end
        @(negedge clk);
        n_checks++;
        if (o_cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL note_on_one_cycle valid=%b expected 0", o_cmd_valid);
        end
        @(posedge clk); #1;
        idle(3);
        n_checks++;
        if (got.size() != 1) begin
            n_fail++; $display("FAIL note_on_count got=%0d expected 1", got.size());
        end
    endtask

    task automatic test_running_status();
        logic [15:0] exp[$] = '{16'hC050, 16'h4000};
        got.delete();
        send(8'h90); send(8'h40); send(8'h50); send(8'h40); send(8'h00);
        idle(5);
        n_checks++;
        if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL running_count got=%0d expected %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp[i]) begin
                n_fail++; $display("FAIL running_word%0d got=%h expected %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_realtime_channel();
        got.delete();
        send(8'h90); send(8'hF8); send(8'h45); send(8'hFE); send(8'h10);
        send(8'h91); send(8'h45); send(8'h10);
        idle(5);
        n_checks++;
        if (got.size() != 1) begin
            n_fail++; $display("FAIL realtime_count got=%0d expected 1", got.size());
        end else begin
            n_checks++;
            if (got[0] !== 16'hC510) begin
                n_fail++; $display("FAIL realtime_word got=%h expected c510", got[0]);
            end
        end
    endtask

    task automatic test_special();
        logic [15:0] exp[$] = '{16'h7F00, 16'h8000};
        got.delete();
        send(8'hB0); send(8'h7B); send(8'h00);
        send(8'hC0); send(8'h05);
        send(8'h90); send(8'h00); send(8'h40);
        send(8'h80); send(8'h7F); send(8'h00);
        idle(5);
        n_checks++;
        if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL special_count got=%0d expected %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp[i]) begin
                n_fail++; $display("FAIL special_word%0d got=%h expected %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp[$];
        i_cmd_ready = 1'b0;
        got.delete();
        for (int i = 0; i < 6; i++) begin
            send(8'h90); send(8'(10 + i)); send(8'(20 + i));
            exp.push_back(16'h8000 + 16'((10 + i) * 256 + 20 + i));
        end
        idle(4);
        n_checks++;
        if (o_overflow !== 1'b1 || o_cmd_valid !== 1'b1 || o_cmd !== exp[0]) begin
            n_fail++;
            $display("FAIL overflow_full ovf=%b valid=%b cmd=%h expected 1/1/%h", o_overflow, o_cmd_valid, o_cmd, exp[0]);
        end
        i_cmd_ready = 1'b1;
        idle(8);
        n_checks++;
        if (got.size() != DEPTH) begin
            n_fail++; $display("FAIL overflow_drain_count got=%0d expected %0d", got.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp[i]) begin
                n_fail++; $display("FAIL overflow_word%0d got=%h expected %h", i, got[i], exp[i]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (o_cmd_valid !== 1'b0 || o_overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_after valid=%b ovf=%b expected 0/1", o_cmd_valid, o_overflow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        send(8'h90); send(8'h45);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (o_cmd_valid !== 1'b0 || o_cmd !== 16'h0000 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid valid=%b cmd=%h ovf=%b expected 0/0000/0", o_cmd_valid, o_cmd, o_overflow);
        end
        got.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'h64);
        idle(5);
        n_checks++;
        if (got.size() != 0 || o_cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_discard got=%0d valid=%b expected 0/0", got.size(), o_cmd_valid);
        end
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] st[9]  = '{8'h80, 8'h90, 8'hB0, 8'hC0, 8'h91, 8'hA0, 8'hF0, 8'hF8, 8'hE0};
        logic [7:0] dat[5] = '{8'h00, 8'h7F, 8'd120, 8'd123, 8'h01};
        int r = $urandom_range(0, 99);
        if (r < 25) return st[$urandom_range(0, 8)];
        if (r < 35) return dat[$urandom_range(0, 4)];
        return 8'($urandom_range(0, 127));
    endfunction

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            i_byte_valid = $urandom_range(0, 2) != 0;
            i_byte       = rand_byte();
            i_cmd_ready  = $urandom_range(0, 99) < (((c / 250) % 2 == 0) ? 85 : 25);
            @(negedge clk);
            n_checks++;
            if (o_cmd_valid !== (mq.size() > 0)) begin
                n_fail++; $display("FAIL random_valid cycle=%0d valid=%b expected %b", c, o_cmd_valid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                n_checks++;
                if (o_cmd !== mq[0]) begin
                    n_fail++; $display("FAIL random_cmd cycle=%0d cmd=%h expected %h", c, o_cmd, mq[0]);
                end
            end
            n_checks++;
            if (o_overflow !== m_ovf) begin
                n_fail++; $display("FAIL random_overflow cycle=%0d ovf=%b expected %b", c, o_overflow, m_ovf);
            end
            @(posedge clk); #1;
        end
        i_byte_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_realtime_channel();
        test_special();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_cmd_parser.md
MIDI_CMD_PARSER -- requirements
Module: midi_cmd_parser

Interface
REQ-001 SHALL have parameter CHANNEL, default 0; MIDI channel (0-15) accepted when OMNI=0.
REQ-002 SHALL have parameter OMNI, default 0; 1 = accept channel messages on all channels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4; command FIFO entries, power of two.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-low (asserted at 0).
REQ-006 i_byte  in  8  received MIDI byte from UART receiver.
REQ-007 i_byte_valid  in  1  one-cycle strobe, i_byte valid.
REQ-008 o_cmd  out  16  synthesizer command word {on, note[6:0], velocity[7:0]}; feeds avs_s0_writedata[15:0].
REQ-009 o_cmd_valid  out  1  FIFO non-empty; o_cmd holds the head entry.
REQ-010 i_cmd_ready  in  1  consumer accepts head when o_cmd_valid && i_cmd_ready.
REQ-011 o_overflow  out  1  sticky: a completed command was dropped because the FIFO was full.

Function
REQ-012 Parser FSM states SHALL be IDLE (no running status), WAIT_D1, WAIT_D2, SKIP.
REQ-013 Bytes 0xF8-0xFF (realtime) SHALL be ignored with no change to state or running status.
REQ-014 Status 0x8n/0x9n/0xBn on an accepted channel SHALL latch running status and go to WAIT_D1; 0xCn SHALL do the same.
REQ-015 Any other status byte (0xF0-0xF7, 0xAn, 0xDn, 0xEn, or a non-accepted channel) SHALL clear running status and go to SKIP.
REQ-016 A data byte (bit7=0) in IDLE or SKIP SHALL be discarded without leaving that state.
REQ-017 In WAIT_D1 a data byte SHALL be stored as D1; for 0xCn the message completes immediately, otherwise go to WAIT_D2.
REQ-018 In WAIT_D2 a data byte completes the message and the FSM SHALL return to WAIT_D1 (running status retained).
REQ-019 A status byte in WAIT_D1/WAIT_D2 SHALL abort the partial message and be processed per REQ-014/015.
REQ-020 Note-on (0x9n) with velocity>0 SHALL emit {1, D1, D2}; velocity 0 SHALL emit {0, D1, 8'h00}.
REQ-021 Note-off (0x8n) SHALL emit {0, D1, D2}.
REQ-022 Note-on/off with D1 = 0 or D1 = 127 SHALL emit nothing (those encodings are reserved control words).
REQ-023 0xBn with D1 = 120 or 123 SHALL emit stop-all 16'h7F00; other controllers SHALL emit nothing.
REQ-024 0xCn (program change) SHALL emit wave-switch 16'h8000, irrespective of D1.
REQ-025 Emitted word SHALL be written to the FIFO on the cycle after the completing i_byte_valid; o_cmd_valid SHALL rise one cycle later still if the FIFO was empty (two-cycle byte-to-valid latency).
REQ-026 FIFO SHALL be show-ahead: o_cmd equals the oldest entry whenever o_cmd_valid=1; o_cmd is don't-care otherwise.
REQ-027 Pop SHALL occur on o_cmd_valid && i_cmd_ready; i_cmd_ready while empty SHALL have no effect.
REQ-028 Push while full without simultaneous pop SHALL drop the new word, keep contents, and set o_overflow.
REQ-029 Push and pop in the same cycle SHALL both take effect, including when full or holding one entry; occupancy unchanged.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH with no loss of order.

Reset
REQ-031 Reset asserted SHALL immediately force FSM=IDLE, running status cleared, FIFO empty, o_cmd_valid=0, o_cmd=16'h0000, o_overflow=0.
REQ-032 Reset mid-message SHALL discard the partial message; first byte after release is parsed from IDLE.
REQ-033 o_overflow SHALL clear only on reset.

Structure
REQ-034 Shared package SHALL hold MIDI status nibbles, CC numbers 120/123, CMD_STOP_ALL=16'h7F00, CMD_WAVE_SWITCH=16'h8000, and the FSM state encoding.
REQ-035 FIFO SHALL be a sub-module named cmd_fifo (parameterised width/depth, show-ahead); parser FSM stays in midi_cmd_parser.

Verification
REQ-036 Bytes 0x90,0x45,0x64, ready=1 -> one word 16'hC564, o_cmd_valid high exactly one cycle, two cycles after the last strobe.
REQ-037 Running status: 0x90,0x40,0x50,0x40,0x00 -> 16'hC050 then 16'h4000.
REQ-038 0x90,0xF8,0x45,0xFE,0x10 -> single 16'hC510 (realtime ignored); 0x91 with CHANNEL=0, OMNI=0 followed by 0x45,0x10 -> nothing.
REQ-039 0xB0,0x7B,0x00 -> 16'h7F00; 0xC0,0x05 -> 16'h8000; 0x90,0x00,0x40 and 0x80,0x7F,0x00 -> nothing.
REQ-040 ready=0, six complete note-ons -> four entries held in order, o_overflow=1; then ready=1 -> first four words drain in order, o_cmd_valid falls.
REQ-041 Reset asserted after 0x90,0x45 -> outputs at reset values; after release, 0x64 alone -> nothing emitted.
